// File: rtl/eth_frame_detector_mem_arbiter_pkg.sv
// ============================================================================
// Module   : eth_frame_detector_mem_arbiter_pkg
// Brief    : shared FSM state type and rotating-priority search for the BRAM arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

package eth_frame_detector_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;
  localparam int SEARCH_W  = MAX_IDX_W + 1;

  // Returns {found, index}: first set bit of req[0..num-1] scanning from start with wrap.
  function automatic logic [SEARCH_W-1:0] rotate_search(
    input logic [MAX_REQ-1:0]  req,
    input logic [SEARCH_W-1:0] num,
    input logic [SEARCH_W-1:0] start
  );
    logic [SEARCH_W-1:0] res;
    logic [SEARCH_W-1:0] idx;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = start + SEARCH_W'(k);
      if (idx >= num) idx = idx - num;
      if ((SEARCH_W'(k) < num) && !res[SEARCH_W-1] && req[idx[SEARCH_W-2:0]])
        res = {1'b1, idx[SEARCH_W-2:0]};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/eth_frame_detector_rr_select.sv
// ============================================================================
// Module   : eth_frame_detector_rr_select
// Brief    : picks the winning requester; round-robin from ptr+1, or fixed
//            lowest-index priority when MEM_ARB_FIXED_PRIO_EN is defined
// Revision : 1.0
// ============================================================================
`default_nettype none

module eth_frame_detector_rr_select
  import eth_frame_detector_mem_arbiter_pkg::*;
#(
  parameter int C_NUM_REQ = 2,
  parameter int C_GRANT_W = 1
) (
  input  logic [C_NUM_REQ-1:0] req_vec,
  input  logic [C_GRANT_W-1:0] ptr,
  output logic [C_GRANT_W-1:0] grant_idx,
  output logic                 grant_valid
);

  logic [C_GRANT_W-1:0] start_idx;
  logic [SEARCH_W-1:0]  search;

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign start_idx  = '0;
`else
  assign start_idx = (ptr == C_GRANT_W'(C_NUM_REQ - 1)) ? '0 : ptr + 1'b1;
`endif

  assign search      = rotate_search(MAX_REQ'(req_vec), SEARCH_W'(C_NUM_REQ), SEARCH_W'(start_idx));
  assign grant_idx   = C_GRANT_W'(search[SEARCH_W-2:0]);
  assign grant_valid = search[SEARCH_W-1];

endmodule

`default_nettype wire

// File: rtl/eth_frame_detector_mem_arbiter.sv
// ============================================================================
// Module   : eth_frame_detector_mem_arbiter
// Brief    : serialises level-req / pulse-ack requesters onto one BRAM port
//            (MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin)
// Revision : 1.0
// ============================================================================
`default_nettype none

module eth_frame_detector_mem_arbiter
  import eth_frame_detector_mem_arbiter_pkg::*;
#(
  parameter int C_NUM_REQ     = 2,
  parameter int C_DATA_WIDTH  = 32,
  parameter int C_ADDR_WIDTH  = 11,
  parameter int C_MEM_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [C_NUM_REQ-1:0]              req_req,
  input  logic [C_NUM_REQ-1:0]              req_we,
  input  logic [C_NUM_REQ*C_ADDR_WIDTH-1:0] req_addr,
  input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_wdata,
  output logic [C_NUM_REQ-1:0]              req_ack,
  output logic [C_DATA_WIDTH-1:0]           req_rdata,
  output logic                              bram_en,
  output logic                              bram_we,
  output logic [C_ADDR_WIDTH-1:0]           bram_addr,
  output logic [C_DATA_WIDTH-1:0]           bram_wdata,
  input  logic [C_DATA_WIDTH-1:0]           bram_rdata
);

  localparam int C_GRANT_W = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
  localparam int C_CNT_W   = 2;

  state_e                   state_q, state_d;
  logic [C_GRANT_W-1:0]     grant_q, grant_d;
  logic [C_GRANT_W-1:0]     ptr_q, ptr_d;
  logic [C_NUM_REQ-1:0]     mask_q, mask_d;
  logic [C_CNT_W-1:0]       cnt_q, cnt_d;
  logic [C_NUM_REQ-1:0]     ack_q, ack_d;
  logic                     en_q, en_d;
  logic                     we_q, we_d;
  logic [C_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [C_DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [C_DATA_WIDTH-1:0]  rdata_q, rdata_d;

  logic [C_NUM_REQ-1:0]     req_vec;
  logic [C_GRANT_W-1:0]     win_idx;
  logic                     win_valid;
  logic                     win_we;
  logic [C_ADDR_WIDTH-1:0]  win_addr;
  logic [C_DATA_WIDTH-1:0]  win_wdata;

  // The requester acked last cycle may still hold req; keep it out of this arbitration.
  assign req_vec = req_req & ~mask_q;

  eth_frame_detector_rr_select #(
    .C_NUM_REQ (C_NUM_REQ),
    .C_GRANT_W (C_GRANT_W)
  ) u_select (
    .req_vec     (req_vec),
    .ptr         (ptr_q),
    .grant_idx   (win_idx),
    .grant_valid (win_valid)
  );

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (win_idx == C_GRANT_W'(i)) begin
        win_we    = req_we[i];
        win_addr  = req_addr[i*C_ADDR_WIDTH +: C_ADDR_WIDTH];
        win_wdata = req_wdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    mask_d  = '0;
    cnt_d   = cnt_q;
    ack_d   = '0;
    en_d    = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          grant_d = win_idx;
          en_d    = 1'b1;
          we_d    = win_we;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          ack_d[grant_q] = 1'b1;
          state_d        = ST_ACK;
        end else begin
          cnt_d   = C_CNT_W'(C_MEM_LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == C_CNT_W'(1)) begin
          rdata_d        = bram_rdata;
          ack_d[grant_q] = 1'b1;
          state_d        = ST_ACK;
        end
      end
      ST_ACK: begin
        ptr_d           = grant_q;
        mask_d[grant_q] = 1'b1;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ack    = ack_q;
  assign req_rdata  = rdata_q;
  assign bram_en    = en_q;
  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_eth_frame_detector_mem_arbiter.sv
// ============================================================================
// Module   : tb_eth_frame_detector_mem_arbiter
// Brief    : scoreboard bench for the BRAM arbiter with a latency-L BRAM model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_eth_frame_detector_mem_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int L  = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_req, req_we, req_ack;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   req_rdata, bram_wdata, bram_rdata;
  logic            bram_en, bram_we;
  logic [AW-1:0]   bram_addr;

  always #5 clk = ~clk;

  eth_frame_detector_mem_arbiter #(
    .C_NUM_REQ(N), .C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW), .C_MEM_LATENCY(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_req(req_req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ack(req_ack), .req_rdata(req_rdata), .bram_en(bram_en),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            t_issue;
    int            lat;
  } exp_t;

  exp_t          exp_q [N][$];
  int            order_q [$];
  logic [DW-1:0] ref_mem [2048];
  int            n_checks, n_fail, cyc, en_count, ack_count, n_issued;

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 5) return 32'hDEADBEEF;
    return 32'h5A000000 ^ (32'(a) * 32'h00010203);
  endfunction

  // BRAM model: read data appears L cycles after the enable cycle.
  logic [DW-1:0] bram_mem [2048];
  bit            bram_written [2048];
  logic [DW-1:0] rd_pipe [L];

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        bram_mem[bram_addr]     <= bram_wdata;
        bram_written[bram_addr] <= 1'b1;
      end else begin
        rd_pipe[0] <= bram_written[bram_addr] ? bram_mem[bram_addr] : init_word(int'(bram_addr));
      end
    end
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rdata = rd_pipe[L-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic monitor();
    bit   hit;
    exp_t e;
    forever begin
      @(negedge clk);
      if (bram_en) begin
        en_count++;
        hit = 1'b0;
        for (int r = 0; r < N; r++)
          if (exp_q[r].size() > 0)
            if (exp_q[r][0].we == bram_we && exp_q[r][0].addr == bram_addr &&
                (!bram_we || exp_q[r][0].data == bram_wdata))
              hit = 1'b1;
        check("bram_access_matches_pending", 64'(hit), 64'd1);
      end
      if (req_ack != '0) begin
        check("ack_onehot", 64'($countones(req_ack)), 64'd1);
        for (int r = 0; r < N; r++) begin
          if (req_ack[r]) begin
            ack_count++;
            if (order_q.size() > 0) check("grant_order", 64'(r), 64'(order_q.pop_front()));
            if (exp_q[r].size() == 0) begin
              check("spurious_ack", 64'(req_ack), 64'd0);
            end else begin
              e = exp_q[r].pop_front();
              if (!e.we) check($sformatf("rdata_req%0d", r), 64'(req_rdata), 64'(e.data));
              if (e.lat >= 0) check($sformatf("ack_latency_req%0d", r), 64'(cyc - e.t_issue), 64'(e.lat));
            end
          end
        end
      end
    end
  endtask

  task automatic cycle_counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic watchdog();
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run did not complete, got %0d errors so far, required completion", n_fail);
    $fatal(1, "watchdog expired");
  endtask

  // One request under the level-req / pulse-ack protocol; late holds req one extra cycle after ack.
  task automatic do_req(input int r, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input bit late, input bit chk_lat);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    req_we[r]                = we;
    req_addr[r*AW +: AW]     = addr;
    req_wdata[r*DW +: DW]    = data;
    req_req[r]               = 1'b1;
    e.we      = we;
    e.addr    = addr;
    e.data    = we ? data : ref_mem[addr];
    e.t_issue = cyc;
    e.lat     = chk_lat ? (we ? 2 : 2 + L) : -1;
    if (we) ref_mem[addr] = data;
    exp_q[r].push_back(e);
    n_issued++;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = req_ack[r];
    end
    if (!got) check($sformatf("ack_timeout_req%0d", r), 64'd0, 64'd1);
    if (late) begin
      @(posedge clk);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    req_req[r] = 1'b0;
  endtask

  task automatic contend(input int r);
    for (int k = 0; k < 2; k++) do_req(r, 1'b0, 11'(r * 512 + 8 + k), '0, 1'b1, 1'b0);
  endtask

  task automatic rand_req(input int r);
    for (int k = 0; k < 34; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_req(r, 1'($urandom_range(0, 1)), 11'(r * 512 + int'($urandom_range(0, 15))),
             $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, 64'({req_ack, bram_en, bram_we, bram_addr}), 64'd0);
    check({tag, "_data"}, {bram_wdata, req_rdata}, 64'd0);
  endtask

  initial begin
    bit seen;
    rst_n     = 1'b0;
    req_req   = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
    fork
      monitor();
      cycle_counter();
      watchdog();
    join_none

    repeat (2) @(negedge clk);
    check_outputs_zero("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_req(0, 1'b0, 11'h005, '0, 1'b0, 1'b1);
    do_req(1, 1'b1, 11'h7FF, 32'h12345678, 1'b1, 1'b1);
    do_req(0, 1'b0, 11'h7FF, '0, 1'b0, 1'b1);

    // Pointer rests at 0 here, so requester 1 is searched first.
    for (int i = 0; i < 4; i++) order_q.push_back((i % 2 == 0) ? 1 : 0);
    fork
      contend(0);
      contend(1);
    join
    check("order_drained", 64'(order_q.size()), 64'd0);

    fork
      do_req(0, 1'b0, 11'h0AB, '0, 1'b0, 1'b0);
      begin
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          seen = bram_en;
        end
        check("mid_read_enable_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        repeat (2) begin
          @(negedge clk);
          check_outputs_zero("mid_read_reset");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    join

    fork
      rand_req(0);
      rand_req(1);
      rand_req(2);
    join
    repeat (20) @(negedge clk);

    check("pending_after_drain", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
    check("bram_en_count", 64'(en_count), 64'(n_issued + 1));
    check("ack_count", 64'(ack_count), 64'(n_issued));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
